// File: rtl/param_ram.sv
// param_ram: word memory behind an enable/MFC handshake with programmable wait states,
// out-of-range address flagging and abort when the requester drops enable mid-access.
module param_ram #(
    parameter int DW    = 8,
    parameter int AW    = 8,
    parameter int DEPTH = 16,
    parameter int WAIT  = 2
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          enable,
    input  logic          rnw,
    input  logic [AW-1:0] MAR,
    input  logic [DW-1:0] bus,
    output logic [DW-1:0] MBR,
    output logic          MFC,
    output logic          ERR
);
    localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state_q;
    logic [3:0]    cnt_q;
    logic [AW-1:0] addr_q;
    logic          rnw_q;
    logic [DW-1:0] data_q;
    logic [DW-1:0] mbr_q;
    logic          mfc_q;
    logic          err_q;
    logic [DW-1:0] mem [DEPTH];

    logic          hit;
    logic          fin;
    logic [IW-1:0] idx;

    assign hit = {1'b0, addr_q} < DEPTH_L;
    assign idx = addr_q[IW-1:0];
    assign fin = state_q == BUSY && enable && cnt_q == 4'd0;

    // The accept edge is followed by WAIT counted cycles, so DONE (and MFC) land WAIT+1 edges later.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            rnw_q   <= 1'b0;
            data_q  <= '0;
            mbr_q   <= '0;
            mfc_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (enable) begin
                    addr_q  <= MAR;
                    rnw_q   <= rnw;
                    data_q  <= bus;
                    cnt_q   <= 4'(WAIT);
                    state_q <= BUSY;
                end
                BUSY: if (!enable) begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end else if (cnt_q == 4'd0) begin
                    state_q <= DONE;
                    mfc_q   <= 1'b1;
                    err_q   <= !hit;
                    if (rnw_q) mbr_q <= hit ? mem[idx] : '0;
                end else begin
                    cnt_q <= cnt_q - 4'd1;
                end
                DONE: if (!enable) begin
                    state_q <= IDLE;
                    mfc_q   <= 1'b0;
                    err_q   <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Storage is deliberately outside the reset domain: contents survive reset.
    always_ff @(posedge CLK) begin
        if (fin && !rnw_q && hit) mem[idx] <= data_q;
    end

    assign MBR = mbr_q;
    assign MFC = mfc_q;
    assign ERR = err_q;
endmodule

// File: tb/tb_param_ram.sv
// tb_param_ram: three param_ram instances (WAIT=2/0/4) driven from a vector table plus
// hand sequences for abort and asynchronous reset; expected results flow through a scoreboard.
module tb_param_ram;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en    [3];
    logic       rw    [3];
    logic [7:0] mar   [3];
    logic [7:0] wd    [3];
    logic [7:0] mbr   [3];
    logic       mfc   [3];
    logic       err   [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        param_ram #(.DW(8), .AW(8), .DEPTH(16), .WAIT(g == 0 ? 2 : g == 1 ? 0 : 4)) dut (
            .CLK(clk), .RST_N(rst_n), .enable(en[g]), .rnw(rw[g]), .MAR(mar[g]),
            .bus(wd[g]), .MBR(mbr[g]), .MFC(mfc[g]), .ERR(err[g])
        );
    end

    typedef struct {
        int         k;
        bit         r;
        logic [7:0] a;
        logic [7:0] d;
        int         hold;
        logic [7:0] mbr;
        bit         err;
    } vec_t;

    typedef struct {
        logic [7:0] mbr;
        bit         err;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    function automatic int wv(input int k);
        return k == 0 ? 2 : k == 1 ? 0 : 4;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic access(input int k, input bit r, input logic [7:0] a, input logic [7:0] d,
                          input int hold, input logic [7:0] em, input bit ee);
        exp_t e;
        sb.push_back('{em, ee});
        @(negedge clk);
        en[k] = 1'b1; rw[k] = r; mar[k] = a; wd[k] = d;
        @(posedge clk);
        #1;
        rw[k] = ~r; mar[k] = ~a; wd[k] = ~d;
        for (int n = 1; n <= wv(k) + 1; n++) begin
            @(posedge clk);
            #1;
            chk($sformatf("mfc_latency k%0d edge%0d", k, n), 32'(mfc[k]), 32'(n == wv(k) + 1));
        end
        e = sb.pop_front();
        chk($sformatf("mbr k%0d a%0h", k, a), 32'(mbr[k]), 32'(e.mbr));
        chk($sformatf("err k%0d a%0h", k, a), 32'(err[k]), 32'(e.err));
        for (int h = 1; h <= hold; h++) begin
            mar[k] = 8'h03; rw[k] = 1'b1;
            @(posedge clk);
            #1;
            chk($sformatf("hold_mfc k%0d c%0d", k, h), 32'(mfc[k]), 32'd1);
            chk($sformatf("hold_mbr k%0d c%0d", k, h), 32'(mbr[k]), 32'(e.mbr));
        end
        @(negedge clk);
        en[k] = 1'b0;
        @(posedge clk);
        #1;
        chk($sformatf("drop_mfc k%0d", k), 32'(mfc[k]), 32'd0);
        chk($sformatf("drop_err k%0d", k), 32'(err[k]), 32'd0);
        chk($sformatf("drop_mbr k%0d", k), 32'(mbr[k]), 32'(e.mbr));
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            en[i] = 1'b0; rw[i] = 1'b0; mar[i] = '0; wd[i] = '0;
        end
        tbl.push_back('{0, 1'b0, 8'h03, 8'h55, 0, 8'h00, 1'b0});
        tbl.push_back('{0, 1'b1, 8'h03, 8'h00, 0, 8'h55, 1'b0});
        tbl.push_back('{0, 1'b0, 8'h00, 8'h11, 0, 8'h55, 1'b0});
        tbl.push_back('{0, 1'b0, 8'h20, 8'hAA, 0, 8'h55, 1'b1});
        tbl.push_back('{0, 1'b1, 8'h00, 8'h00, 0, 8'h11, 1'b0});
        tbl.push_back('{0, 1'b1, 8'h20, 8'h00, 0, 8'h00, 1'b1});
        tbl.push_back('{0, 1'b0, 8'h0F, 8'hC3, 0, 8'h00, 1'b0});
        tbl.push_back('{0, 1'b1, 8'h0F, 8'h00, 0, 8'hC3, 1'b0});
        tbl.push_back('{0, 1'b0, 8'h10, 8'h5A, 0, 8'hC3, 1'b1});
        tbl.push_back('{0, 1'b1, 8'h10, 8'h00, 0, 8'h00, 1'b1});
        tbl.push_back('{0, 1'b1, 8'h0F, 8'h00, 5, 8'hC3, 1'b0});
        tbl.push_back('{0, 1'b0, 8'h07, 8'hE1, 0, 8'hC3, 1'b0});
        tbl.push_back('{0, 1'b1, 8'h07, 8'h00, 0, 8'hE1, 1'b0});
        tbl.push_back('{1, 1'b0, 8'h09, 8'h03, 0, 8'h00, 1'b0});
        tbl.push_back('{1, 1'b1, 8'h09, 8'h00, 0, 8'h03, 1'b0});
        tbl.push_back('{2, 1'b0, 8'h05, 8'h12, 0, 8'h00, 1'b0});
        tbl.push_back('{2, 1'b1, 8'h05, 8'h00, 0, 8'h12, 1'b0});

        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset_mbr k%0d", i), 32'(mbr[i]), 32'd0);
            chk($sformatf("reset_mfc k%0d", i), 32'(mfc[i]), 32'd0);
            chk($sformatf("reset_err k%0d", i), 32'(err[i]), 32'd0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i])
            access(tbl[i].k, tbl[i].r, tbl[i].a, tbl[i].d, tbl[i].hold, tbl[i].mbr, tbl[i].err);

        // Abort: WAIT=4 write dropped after two BUSY cycles must leave no trace.
        @(negedge clk);
        en[2] = 1'b1; rw[2] = 1'b0; mar[2] = 8'h05; wd[2] = 8'h77;
        repeat (3) @(posedge clk);
        @(negedge clk);
        en[2] = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("abort_mfc c%0d", c), 32'(mfc[2]), 32'd0);
            chk($sformatf("abort_mbr c%0d", c), 32'(mbr[2]), 32'h12);
        end
        access(2, 1'b1, 8'h05, 8'h00, 0, 8'h12, 1'b0);

        // Asynchronous reset between edges in the middle of a write.
        @(negedge clk);
        en[0] = 1'b1; rw[0] = 1'b0; mar[0] = 8'h07; wd[0] = 8'h99;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_mfc", 32'(mfc[0]), 32'd0);
        chk("rst_mid_err", 32'(err[0]), 32'd0);
        chk("rst_mid_mbr", 32'(mbr[0]), 32'd0);
        @(negedge clk);
        en[0] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        access(0, 1'b1, 8'h07, 8'h00, 0, 8'hE1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end
endmodule
